z80_ld_dd_ind_nn_seq: RTL and testbench

//  Multi-cycle execution sequencer for LD dd,(nn) (ED 01dd1011 nn_lo nn_hi): the read-side

---
 rtl/z80_ld_dd_ind_nn_seq.sv | 147 ++++++++++++++
 tb/tb_z80_ld_dd_ind_nn_seq.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_ld_dd_ind_nn_seq.sv
// Execution sequencer for the Z80 LD dd,(nn) instruction (ED 01dd1011 nn_lo nn_hi).
// The sequencer fetches the 16-bit operand nn, reads the little-endian word at
// (nn),(nn+1) and writes it to register pair dd. It also exports trace values for
// the formal checker.
module z80_ld_dd_ind_nn_seq #(
  parameter int unsigned MAX_WAIT = 255  // cycles to wait for mem_ack before abort; 0 = forever
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  dd,
  input  logic [15:0] ip_in,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        reg_wr_en,
  output logic [1:0]  reg_wr_sel,
  output logic [15:0] reg_wr_data,
  output logic [15:0] ip_out,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] fi_nn,
  output logic [15:0] fi_raddr2,
  output logic [7:0]  fi_rdata,
  output logic [7:0]  fi_rdata2
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_LO,
    S_FETCH_HI,
    S_READ_LO,
    S_READ_HI,
    S_WB
  } state_e;

  // The wait counter only needs to reach MAX_WAIT-1 before the abort fires.
  localparam int unsigned WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = (MAX_WAIT == 0) ? '0 : WW'(MAX_WAIT - 1);

  state_e        state_q;
  logic [1:0]    dd_q;
  logic [15:0]   ip_q;
  logic [WW-1:0] wait_q;
  logic          bus_state;
  logic          timeout_hit;

  // The bus request and busy flag are plain decodes of the state register.
  always_comb begin
    bus_state   = (state_q == S_FETCH_LO) || (state_q == S_FETCH_HI) ||
                  (state_q == S_READ_LO)  || (state_q == S_READ_HI);
    timeout_hit = (MAX_WAIT != 0) && (wait_q == WAIT_LAST);
  end

  assign mem_rd = bus_state;
  assign busy   = (state_q != S_IDLE);

  // Sequencer: state, latched operands, bus address, trace values and output strobes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: every register, including the trace outputs, is cleared so the
      // outputs read as zero after reset rather than as stale data.
      state_q     <= S_IDLE;
      dd_q        <= '0;
      ip_q        <= '0;
      wait_q      <= '0;
      mem_addr    <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_sel  <= '0;
      reg_wr_data <= '0;
      ip_out      <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      fi_nn       <= '0;
      fi_raddr2   <= '0;
      fi_rdata    <= '0;
      fi_rdata2   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side sees
      // the value from before this edge regardless of statement order.
      reg_wr_en <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            dd_q     <= dd;
            ip_q     <= ip_in;
            mem_addr <= ip_in + 16'd2;
            wait_q   <= '0;
            state_q  <= S_FETCH_LO;
          end
        end

        S_FETCH_LO, S_FETCH_HI, S_READ_LO, S_READ_HI: begin
          if (mem_ack) begin
            // Each ack moves the address on so that back-to-back acks give one byte per cycle.
            wait_q <= '0;
            unique case (state_q)
              S_FETCH_LO: begin
                fi_nn[7:0] <= mem_rdata;
                mem_addr   <= ip_q + 16'd3;
                state_q    <= S_FETCH_HI;
              end
              S_FETCH_HI: begin
                fi_nn[15:8] <= mem_rdata;
                mem_addr    <= {mem_rdata, fi_nn[7:0]};
                fi_raddr2   <= {mem_rdata, fi_nn[7:0]} + 16'd1;
                state_q     <= S_READ_LO;
              end
              S_READ_LO: begin
                fi_rdata <= mem_rdata;
                mem_addr <= fi_raddr2;
                state_q  <= S_READ_HI;
              end
              default: begin
                fi_rdata2   <= mem_rdata;
                reg_wr_data <= {mem_rdata, fi_rdata};
                reg_wr_sel  <= dd_q;
                ip_out      <= ip_q + 16'd4;
                reg_wr_en   <= 1'b1;
                done        <= 1'b1;
                state_q     <= S_WB;
              end
            endcase
          end else if (timeout_hit) begin
            // Abort: drop the request with no register write; a late ack lands in IDLE.
            err     <= 1'b1;
            wait_q  <= '0;
            state_q <= S_IDLE;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end

        // The write strobe is already asserted in this cycle; a start here is ignored.
        S_WB: state_q <= S_IDLE;

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_ld_dd_ind_nn_seq.sv
// Bench for z80_ld_dd_ind_nn_seq: a memory responder with optional random wait
// states, a queue of expected bus addresses and a queue of expected completions.
module tb_z80_ld_dd_ind_nn_seq;

  localparam int unsigned MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  dd = '0;
  logic [15:0] ip_in = '0;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        reg_wr_en;
  logic [1:0]  reg_wr_sel;
  logic [15:0] reg_wr_data;
  logic [15:0] ip_out;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] fi_nn;
  logic [15:0] fi_raddr2;
  logic [7:0]  fi_rdata;
  logic [7:0]  fi_rdata2;

  z80_ld_dd_ind_nn_seq #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .dd(dd), .ip_in(ip_in),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .reg_wr_en(reg_wr_en), .reg_wr_sel(reg_wr_sel), .reg_wr_data(reg_wr_data),
    .ip_out(ip_out), .busy(busy), .done(done), .err(err),
    .fi_nn(fi_nn), .fi_raddr2(fi_raddr2), .fi_rdata(fi_rdata), .fi_rdata2(fi_rdata2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] data;
    logic [15:0] ipo;
    logic [15:0] nn;
    logic [15:0] raddr2;
    logic [7:0]  rd1;
    logic [7:0]  rd2;
    int          start_cyc;
    int          waits0;
  } exp_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int total_waits = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  int err_cyc = -1;
  int rand_wait = 0;
  bit stall_en = 1'b0;
  logic [15:0] stall_addr = '0;

  logic [7:0]  mem [0:65535];
  exp_t        exp_q [$];
  logic [15:0] addr_q [$];

  bit          in_req = 1'b0;
  logic [15:0] req_addr = '0;
  int          waits_left = 0;
  exp_t        mon_e;
  logic [15:0] mon_a;

  // Completion monitor and memory responder, both acting 1 time unit after the rising edge.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (reg_wr_en === 1'b1) wr_cnt++;
    if (done === 1'b1 || reg_wr_en === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done cyc=%0d done=%b reg_wr_en=%b, no completion outstanding", cyc, done, reg_wr_en);
      end else begin
        mon_e = exp_q.pop_front();
        if ({done, reg_wr_en} !== 2'b11) begin
          miscompares++;
          $display("FAIL strobes cyc=%0d got done,wr=%b want 11", cyc, {done, reg_wr_en});
        end
        if (reg_wr_sel !== mon_e.sel) begin
          miscompares++;
          $display("FAIL wr_sel got=%b want=%b", reg_wr_sel, mon_e.sel);
        end
        if (reg_wr_data !== mon_e.data) begin
          miscompares++;
          $display("FAIL wr_data got=%h want=%h", reg_wr_data, mon_e.data);
        end
        if (ip_out !== mon_e.ipo) begin
          miscompares++;
          $display("FAIL ip_out got=%h want=%h", ip_out, mon_e.ipo);
        end
        if ({fi_nn, fi_raddr2, fi_rdata, fi_rdata2} !== {mon_e.nn, mon_e.raddr2, mon_e.rd1, mon_e.rd2}) begin
          miscompares++;
          $display("FAIL fi_trace got=%h/%h/%h/%h want=%h/%h/%h/%h", fi_nn, fi_raddr2, fi_rdata, fi_rdata2,
                   mon_e.nn, mon_e.raddr2, mon_e.rd1, mon_e.rd2);
        end
        if (cyc != mon_e.start_cyc + 5 + (total_waits - mon_e.waits0)) begin
          miscompares++;
          $display("FAIL latency got_cycle=%0d want_cycle=%0d", cyc, mon_e.start_cyc + 5 + (total_waits - mon_e.waits0));
        end
      end
    end

    mem_ack = 1'b0;
    if (mem_rd === 1'b1 && !(stall_en && mem_addr == stall_addr)) begin
      if (!in_req) begin
        in_req     = 1'b1;
        req_addr   = mem_addr;
        waits_left = (rand_wait > 0) ? int'($urandom_range(rand_wait, 0)) : 0;
      end else begin
        vectors++;
        if (mem_addr !== req_addr) begin
          miscompares++;
          $display("FAIL addr_stable cyc=%0d got=%h want=%h", cyc, mem_addr, req_addr);
        end
      end
      if (waits_left == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        in_req    = 1'b0;
        vectors++;
        if (addr_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_read cyc=%0d addr=%h, no read outstanding", cyc, mem_addr);
        end else begin
          mon_a = addr_q.pop_front();
          if (mem_addr !== mon_a) begin
            miscompares++;
            $display("FAIL read_addr cyc=%0d got=%h want=%h", cyc, mem_addr, mon_a);
          end
        end
      end else begin
        waits_left--;
        total_waits++;
      end
    end else begin
      in_req = 1'b0;
    end
  end

  // Load memory, queue the expected reads and result, then pulse start for one cycle.
  task automatic issue(input logic [1:0] d, input logic [15:0] ip, input logic [15:0] nn,
                       input logic [7:0] lo, input logic [7:0] hi, input int n_reads, input bit expect_done);
    logic [15:0] a2, a3, n1;
    exp_t e;
    a2 = ip + 16'd2;
    a3 = ip + 16'd3;
    n1 = nn + 16'd1;
    mem[a2] = nn[7:0];
    mem[a3] = nn[15:8];
    mem[nn] = lo;
    mem[n1] = hi;
    if (n_reads > 0) addr_q.push_back(a2);
    if (n_reads > 1) addr_q.push_back(a3);
    if (n_reads > 2) addr_q.push_back(nn);
    if (n_reads > 3) addr_q.push_back(n1);
    @(negedge clk);
    e.sel = d;
    e.data = {hi, lo};
    e.ipo = ip + 16'd4;
    e.nn = nn;
    e.raddr2 = n1;
    e.rd1 = lo;
    e.rd2 = hi;
    e.start_cyc = cyc;
    e.waits0 = total_waits;
    if (expect_done) exp_q.push_back(e);
    start = 1'b1;
    dd = d;
    ip_in = ip;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for all outstanding work to finish, then confirm the DUT stays idle.
  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0 || addr_q.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_%s pending_results=%0d pending_reads=%0d busy=%b want 0/0/0", tag, exp_q.size(), addr_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({mem_rd, mem_addr, reg_wr_en, reg_wr_sel, reg_wr_data, ip_out, busy, done, err,
         fi_nn, fi_raddr2, fi_rdata, fi_rdata2} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs mem_rd=%b addr=%h busy=%b data=%h ip_out=%h fi_nn=%h want all 0",
               mem_rd, mem_addr, busy, reg_wr_data, ip_out, fi_nn);
    end
  endtask

  task automatic test_basic();
    rand_wait = 0;
    issue(2'b01, 16'h0100, 16'h1234, 8'hCD, 8'hAB, 4, 1'b1);
    // Pulse start during the WB cycle; it must be ignored.
    repeat (4) @(negedge clk);
    start = 1'b1;
    ip_in = 16'h7000;
    @(negedge clk);
    start = 1'b0;
    wait_drain("basic");
    vectors++;
    if ({reg_wr_sel, reg_wr_data, ip_out} !== {2'b01, 16'hABCD, 16'h0104}) begin
      miscompares++;
      $display("FAIL basic_hold sel=%b data=%h ip_out=%h want 01/abcd/0104", reg_wr_sel, reg_wr_data, ip_out);
    end
  endtask

  task automatic test_wrap_nn();
    issue(2'b11, 16'h2000, 16'hFFFF, 8'h55, 8'hAA, 4, 1'b1);
    wait_drain("wrap_nn");
    vectors++;
    if ({reg_wr_data, fi_raddr2} !== {16'hAA55, 16'h0000}) begin
      miscompares++;
      $display("FAIL wrap_nn data=%h raddr2=%h want aa55/0000", reg_wr_data, fi_raddr2);
    end
  endtask

  task automatic test_wrap_ip();
    issue(2'b10, 16'hFFFD, 16'h5678, 8'h9A, 8'hBC, 4, 1'b1);
    wait_drain("wrap_ip");
    vectors++;
    if (ip_out !== 16'h0001) begin
      miscompares++;
      $display("FAIL wrap_ip ip_out=%h want 0001", ip_out);
    end
  endtask

  task automatic test_random_waits();
    logic [15:0] ip, nn;
    rand_wait = 3;
    for (int i = 0; i < 10; i++) begin
      ip = 16'($urandom);
      nn = ip + 16'h4000 + 16'($urandom_range(16'h3FFF, 0));
      issue(2'($urandom), ip, nn, 8'($urandom), 8'($urandom), 4, 1'b1);
      if (i % 2 == 1) begin
        @(negedge clk);
        start = 1'b1;
        ip_in = 16'($urandom);
        dd = 2'($urandom);
        @(negedge clk);
        start = 1'b0;
      end
      wait_drain("random");
    end
    rand_wait = 0;
  endtask

  task automatic test_timeout();
    logic [15:0] nn;
    int n, t, wr0, err0;
    nn = 16'h3344;
    stall_en = 1'b1;
    stall_addr = nn;
    wr0 = wr_cnt;
    err0 = err_cnt;
    issue(2'b00, 16'h0800, nn, 8'h11, 8'h22, 2, 1'b0);
    n = 0;
    while (!(mem_rd === 1'b1 && mem_addr === nn) && n < 20) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    n = 0;
    while (err_cnt == err0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (err_cnt == err0 || err_cyc != t + 4 || mem_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_err err_cycle=%0d want=%0d mem_rd=%b want 0", err_cyc, t + 4, mem_rd);
    end
    @(negedge clk);
    vectors++;
    if ({err, busy, mem_rd} !== 3'b000 || wr_cnt != wr0) begin
      miscompares++;
      $display("FAIL timeout_after err=%b busy=%b mem_rd=%b writes=%0d want 0/0/0/0", err, busy, mem_rd, wr_cnt - wr0);
    end
    stall_en = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (err_cnt != err0 + 1) begin
      miscompares++;
      $display("FAIL timeout_pulses got=%0d want 1", err_cnt - err0);
    end
    issue(2'b01, 16'h0900, 16'h4455, 8'h66, 8'h77, 4, 1'b1);
    wait_drain("after_timeout");
  endtask

  task automatic test_reset_mid();
    logic [15:0] nn;
    int n, wr0, err0;
    nn = 16'h6000;
    stall_en = 1'b1;
    stall_addr = nn + 16'd1;
    wr0 = wr_cnt;
    err0 = err_cnt;
    issue(2'b10, 16'h0A00, nn, 8'h12, 8'h34, 3, 1'b0);
    n = 0;
    while (!(mem_rd === 1'b1 && mem_addr === stall_addr) && n < 20) begin
      @(negedge clk);
      n++;
    end
    reset_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mem_rd, mem_addr, reg_wr_en, reg_wr_sel, reg_wr_data, ip_out, busy, done, err,
         fi_nn, fi_raddr2, fi_rdata, fi_rdata2} !== '0 || n >= 20) begin
      miscompares++;
      $display("FAIL reset_mid mem_rd=%b addr=%h busy=%b done=%b fi_nn=%h ip_out=%h want all 0",
               mem_rd, mem_addr, busy, done, fi_nn, ip_out);
    end
    reset_n = 1'b1;
    stall_en = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (wr_cnt != wr0 || err_cnt != err0) begin
      miscompares++;
      $display("FAIL reset_mid_pulses writes=%0d errs=%0d want 0/0", wr_cnt - wr0, err_cnt - err0);
    end
    issue(2'b11, 16'h0B00, 16'h7000, 8'h9F, 8'h8E, 4, 1'b1);
    wait_drain("after_reset");
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_wrap_nn();
    test_wrap_ip();
    test_random_waits();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
